// File: rtl/alu_seq.sv
// Sequential execution unit: single-cycle integer ops plus iterative
// multiply/divide (one radix-2 step per cycle), behind valid/ready handshakes.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_opr,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] MIN_S    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   CNT_LOAD = SHW'(WIDTH - 1);

  localparam logic [4:0] OP_ADD  = 5'h00, OP_SUB  = 5'h01, OP_AND    = 5'h02, OP_OR    = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04, OP_SLL  = 5'h05, OP_SLT    = 5'h06, OP_SLTU  = 5'h07;
  localparam logic [4:0] OP_SRL  = 5'h08, OP_SRA  = 5'h09, OP_SUBU   = 5'h0A;
  localparam logic [4:0] OP_MUL  = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12, OP_MULHU = 5'h13;
  localparam logic [4:0] OP_DIV  = 5'h14, OP_DIVU = 5'h15, OP_REM    = 5'h16, OP_REMU  = 5'h17;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A request is accepted only in IDLE; a result is offered in DONE and held
  // unchanged until out_ready is seen high at an edge.
  state_e            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, div_q, div_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [3:0]        flag_q, flag_d;

  logic [SHW-1:0]    shamt;
  logic [WIDTH-1:0]  sum, diff, sc_res, a_mag, b_mag;
  logic              sc_ovf, sc_dz, is_iter, is_div, div_ovf_case, go_calc;
  logic              a_signed, b_signed, a_neg, b_neg, neg_init;

  always_comb begin
    shamt        = operand2[SHW-1:0];
    sum          = operand1 + operand2;
    diff         = operand1 - operand2;
    is_iter      = (alu_opr[4:3] == 2'b10);
    is_div       = is_iter && alu_opr[2];
    div_ovf_case = (alu_opr == OP_DIV || alu_opr == OP_REM) &&
                   (operand1 == MIN_S) && (operand2 == '1);
    go_calc      = is_iter && !(is_div && (operand2 == '0 || div_ovf_case));
    sc_res       = operand1;
    sc_ovf       = 1'b0;
    sc_dz        = 1'b0;
    case (alu_opr)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (operand1[MSB] == operand2[MSB]) && (sum[MSB] != operand1[MSB]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (operand1[MSB] != operand2[MSB]) && (diff[MSB] != operand1[MSB]);
      end
      OP_AND:  sc_res = operand1 & operand2;
      OP_OR:   sc_res = operand1 | operand2;
      OP_XOR:  sc_res = operand1 ^ operand2;
      OP_SLL:  sc_res = operand1 << shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, operand1 < operand2};
      OP_SRL:  sc_res = operand1 >> shamt;
      OP_SRA:  sc_res = $signed(operand1) >>> shamt;
      OP_SUBU: sc_res = diff;
      OP_DIV, OP_DIVU: begin
        if (operand2 == '0) begin
          sc_res = '1;
          sc_dz  = 1'b1;
        end else if (div_ovf_case) begin
          sc_res = operand1;
          sc_ovf = 1'b1;
        end
      end
      OP_REM, OP_REMU: begin
        if (operand2 == '0) begin
          sc_res = operand1;
          sc_dz  = 1'b1;
        end else if (div_ovf_case) begin
          sc_res = '0;
          sc_ovf = 1'b1;
        end
      end
      default: sc_res = operand1;
    endcase
    // Iterative ops run on magnitudes; neg_init records the final sign fix.
    a_signed = alu_opr inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = alu_opr inside {OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_signed && operand1[MSB];
    b_neg    = b_signed && operand2[MSB];
    a_mag    = a_neg ? -operand1 : operand1;
    b_mag    = b_neg ? -operand2 : operand2;
    neg_init = (alu_opr == OP_REM) ? a_neg : (a_neg ^ b_neg);
  end

  logic [WIDTH:0]     mul_sum, div_try;
  logic [WIDTH-1:0]   div_sub, step_hi, step_lo, fin;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, div_q} : '0);
    div_try = {hi_q, lo_q[MSB]};
    div_ge  = (div_try >= {1'b0, div_q});
    div_sub = div_try[WIDTH-1:0] - div_q;
    if (op_q[2]) begin
      step_hi = div_ge ? div_sub : div_try[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    case (op_q)
      OP_MUL:                     fin = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:            fin = neg_q ? -step_lo : step_lo;
      default:                    fin = neg_q ? -step_hi : step_hi;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_d    = div_q;
    neg_d    = neg_q;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = alu_opr;
          if (go_calc) begin
            state_d = CALC;
            cnt_d   = CNT_LOAD;
            hi_d    = '0;
            lo_d    = is_div ? a_mag : b_mag;
            div_d   = is_div ? b_mag : a_mag;
            neg_d   = neg_init;
          end else begin
            state_d  = DONE;
            result_d = sc_res;
            flag_d   = {sc_res == '0, sc_res[MSB], sc_ovf, sc_dz};
          end
        end
      end
      CALC: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = fin;
          flag_d   = {fin == '0, fin[MSB], 2'b00};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      flag_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flag      = flag_q;

endmodule
